modem_symbol_framer: RTL
========================

# modem_symbol_framer

Upstream stage of the multimode modem. It accepts bytes over a valid/ready handshake and wraps each one in an asynchronous-style frame: start bit, 8 data bits LSB first, optional parity, then stop. It emits the frame as a paced symbol stream for the modulator, which drives `mod_out`. Bits per symbol follow the mode select: ASK, FSK and PSK carry 1 bit per symbol; QPSK carries 2.

## Interface
- `SYM_DIV`, default 16: clock cycles per symbol; must be ≥2.
- `DIV_W`, default `$clog2(SYM_DIV)`: width of the symbol timer.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `ena` input, 1 bit: global enable; low freezes the block.
- `sel` input, 2 bits: mode select. 0 = ASK, 1 = FSK, 2 = PSK, 3 = QPSK.
- `byte_data` input, 8 bits: byte to transmit.
- `byte_valid` input, 1 bit: `byte_data` is valid.
- `byte_ready` output, 1 bit: block accepts a byte this cycle.
- `sym_out` output, 2 bits: current symbol to the modulator.
- `sym_strobe` output, 1 bit: one-cycle pulse in the first cycle of every new frame symbol.
- `busy` output, 1 bit: a frame is in progress.

## Operation
- **States:** IDLE and SEND.
- **Reset values:**
  - state = IDLE, `busy` = 0, `sym_strobe` = 0.
  - `sym_out` = 2'b01.
  - Timer = 0, symbol index = 0.
- **Idle symbol:** 2'b01 in 1-bit modes and 2'b11 in QPSK, chosen from the live `sel`.
- **`byte_ready`:** combinational, `ena && (state==IDLE || last_cycle)`. `last_cycle` means final symbol AND timer == `SYM_DIV`-1.
- **Accept:** happens when `byte_valid && byte_ready`.
  - Latches `byte_data`, and latches `sel` as the frame mode.
  - Builds bit vector b0..b(N-1): b0 = 0 (start), b1..b8 = data[0..7], then stop = 1.
- **Frame length N:** 10 bits, or 11 with parity.
  - In QPSK an odd N is padded with one extra 1, giving 12.
- **Symbol count:** N in 1-bit modes; N/2 in QPSK (5 symbols, or 6 with parity).
- **Symbol mapping:**
  - 1-bit modes: `sym_out` = {1'b0, bk}.
  - QPSK: `sym_out` = {b(2k+1), b(2k)}; the earlier bit is in the LSB.
- **SEND state:**
  - The timer counts 0..`SYM_DIV`-1 on every `ena` cycle.
  - At wrap, the symbol index advances.
  - After the last symbol, the block returns to IDLE unless a new byte was accepted on `last_cycle`.
- **Mode changes:** a `sel` change mid-frame is ignored until the next accept.
- **`ena` low:** timer, state and outputs hold, `sym_strobe` is forced to 0, and `byte_ready` = 0.
- **Reset mid-frame:** the frame is dropped and all outputs return to their reset values immediately (asynchronously).

## Timing
- **Accept to first symbol:** accept at edge N puts the start symbol on `sym_out` with `sym_strobe`=1 and `busy`=1 after that edge (cycle N+1). The timer restarts at 0.
- **Symbol duration:** each symbol is held for exactly `SYM_DIV` enabled cycles.
- **Frame duration:**
  - 1-bit modes: 10·`SYM_DIV` cycles.
  - QPSK: 5·`SYM_DIV` cycles.
- **Back-to-back frames:** an accept on `last_cycle` makes the next start symbol follow with zero idle gap. `sym_strobe` fires again and `busy` stays 1.
- **Return to idle:** with no accept on `last_cycle`, the cycle after it shows the idle symbol, `busy`=0 and no strobe.
- **Outputs:** `sym_out`, `sym_strobe` and `busy` are registered. `byte_ready` is the only combinational output.

## Configuration
- **Macro `MODEM_FRAMER_PARITY_EN`:**
  - Defined: an even-parity bit (XOR of data) is inserted between data and stop. N = 11; QPSK pads to 12, giving 6 symbols.
  - Undefined: no parity logic is compiled. N = 10; QPSK uses 5 symbols.

## Structure
- **Package `modem_pkg`:**
  - Mode constants `MODE_ASK`, `MODE_FSK`, `MODE_PSK`, `MODE_QPSK`.
  - State enum `framer_state_t` {IDLE, SEND}.
  - Idle-symbol constants `SYM_IDLE_1B` = 2'b01 and `SYM_IDLE_QPSK` = 2'b11.
  - Frame-length constants, conditioned on the macro.
- **Sub-module `modem_sym_timer`:**
  - Divider with `clear`, `ena`, `tick` (at count `SYM_DIV`-1) and `count` outputs.
  - Reused later by the demodulator sampler.

## Test plan
All scenarios use `SYM_DIV`=4.
- **Reset:** assert `rst` mid-frame → `sym_out`=01, `busy`=0, `sym_strobe`=0 at once. After release, `byte_ready`=1 with `ena`=1.
- **PSK:** `sel`=2, byte 0xA5 → symbols LSB 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. There are 10 strobes, 40 cycles of `busy`, then `sym_out`=01.
- **QPSK:** `sel`=3, byte 0xA5 → `sym_out` 10,10,00,01,11 across 20 cycles, then idle 11.
  - With `MODEM_FRAMER_PARITY_EN`: 10,10,00,01,01,11 across 24 cycles.
- **Back-to-back:** `byte_valid` held high with 0x00 then 0xFF in ASK → second start symbol begins the cycle after the 40th, with no idle gap. `byte_ready` is high for exactly one cycle per frame.
- **Enable freeze and mode change:** `ena` low for 7 cycles at the 2nd symbol, then toggle `sel` mid-frame → `sym_out`, timer and index are frozen. The frame stretches to 47 cycles and its mapping stays unchanged.

Source files
------------

// File: rtl/modem_pkg.sv
// -----------------------------------------------------------------------------
// modem_pkg
// Shared types and constants for the modem symbol framer and related blocks.
//   - Mode-select encodings (ASK / FSK / PSK / QPSK)
//   - Framer state enum
//   - Idle-symbol constants
//   - Frame-length constants (depend on MODEM_FRAMER_PARITY_EN)
//   - Helpers: frame builder, symbol mapper, idle-symbol selector
// Optional feature macro: MODEM_FRAMER_PARITY_EN (inserts an even-parity bit).
// -----------------------------------------------------------------------------
package modem_pkg;

    localparam logic [1:0] MODE_ASK  = 2'd0;
    localparam logic [1:0] MODE_FSK  = 2'd1;
    localparam logic [1:0] MODE_PSK  = 2'd2;
    localparam logic [1:0] MODE_QPSK = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } framer_state_t;

    localparam logic [1:0] SYM_IDLE_1B   = 2'b01;
    localparam logic [1:0] SYM_IDLE_QPSK = 2'b11;

    // Storage width of a frame: large enough for the QPSK-padded parity frame.
    localparam int FRAME_W = 12;

`ifdef MODEM_FRAMER_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // QPSK pads an odd frame with one extra 1 so it splits into whole symbols.
    localparam int FRAME_BITS_QPSK = FRAME_BITS + (FRAME_BITS % 2);
    localparam int SYMS_1B         = FRAME_BITS;
    localparam int SYMS_QPSK       = FRAME_BITS_QPSK / 2;

    // b0 = start (0), b1..b8 = data LSB first, optional parity, then 1s
    // (stop bit and any QPSK pad).
    function automatic logic [FRAME_W-1:0] build_frame(input logic [7:0] data);
        logic [FRAME_W-1:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = data;
`ifdef MODEM_FRAMER_PARITY_EN
        f[9]   = ^data;
`endif
        return f;
    endfunction

    // The earliest untransmitted bits sit in the LSBs of the frame register.
    function automatic logic [1:0] map_symbol(input logic [1:0] lsbs, input logic qpsk);
        return qpsk ? lsbs : {1'b0, lsbs[0]};
    endfunction

    function automatic logic [1:0] idle_symbol(input logic [1:0] mode);
        return (mode == MODE_QPSK) ? SYM_IDLE_QPSK : SYM_IDLE_1B;
    endfunction

endpackage

// File: rtl/modem_sym_timer.sv
// -----------------------------------------------------------------------------
// modem_sym_timer
// Symbol-period divider: counts 0..SYM_DIV-1 on enabled cycles and wraps.
// Shared by the framer and the demodulator sampler.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   clear       synchronous restart to 0 (priority over ena)
//   ena         advance the count this cycle
//   tick        count is at SYM_DIV-1 (final cycle of the symbol)
//   count       current count
// -----------------------------------------------------------------------------
module modem_sym_timer #(
    parameter int SYM_DIV = 16,
    parameter int DIV_W   = $clog2(SYM_DIV)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             ena,
    output logic             tick,
    output logic [DIV_W-1:0] count
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(SYM_DIV - 1);

    logic [DIV_W-1:0] r_count;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (ena) begin
            r_count <= (r_count == LAST) ? '0 : r_count + DIV_W'(1);
        end
    end

    assign tick  = (r_count == LAST);
    assign count = r_count;

endmodule

// File: rtl/modem_symbol_framer.sv
// -----------------------------------------------------------------------------
// modem_symbol_framer
// Accepts bytes over valid/ready, wraps each in a start/data/[parity]/stop
// frame and emits it as a paced symbol stream (1 bit/symbol for ASK/FSK/PSK,
// 2 bits/symbol for QPSK), each symbol held for SYM_DIV enabled cycles.
// Optional feature macro: MODEM_FRAMER_PARITY_EN (even parity before stop).
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   ena          global enable; low freezes the block
//   sel          mode select (0 ASK, 1 FSK, 2 PSK, 3 QPSK)
//   byte_data    byte to transmit
//   byte_valid   byte_data is valid
//   byte_ready   byte accepted this cycle if valid (combinational)
//   sym_out      current symbol (registered)
//   sym_strobe   first cycle of each frame symbol (registered)
//   busy         frame in progress (registered)
// -----------------------------------------------------------------------------
module modem_symbol_framer
    import modem_pkg::*;
#(
    parameter int SYM_DIV = 16,
    parameter int DIV_W   = $clog2(SYM_DIV)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [1:0] sel,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic [1:0] sym_out,
    output logic       sym_strobe,
    output logic       busy
);

    localparam logic [DIV_W-1:0] TIMER_LAST = DIV_W'(SYM_DIV - 1);

    framer_state_t      r_state, w_state_next;
    logic [FRAME_W-1:0] r_frame, w_frame_next, w_new_frame, w_shifted;
    logic               r_qpsk, w_qpsk_next, w_new_qpsk;
    logic [3:0]         r_idx, w_idx_next;
    logic [1:0]         r_sym, w_sym_next;
    logic               r_strobe, w_strobe_next;
    logic               r_busy, w_busy_next;

    logic               w_tick, w_timer_clear;
    logic [DIV_W-1:0]   w_count;
    logic               w_last_sym, w_last_cycle, w_accept;

    modem_sym_timer #(
        .SYM_DIV (SYM_DIV),
        .DIV_W   (DIV_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (w_timer_clear),
        .ena   (ena),
        .tick  (w_tick),
        .count (w_count)
    );

    assign w_last_sym   = (r_idx == (r_qpsk ? 4'(SYMS_QPSK - 1) : 4'(SYMS_1B - 1)));
    assign w_last_cycle = (r_state == SEND) && w_last_sym && (w_count == TIMER_LAST);
    assign byte_ready   = ena && ((r_state == IDLE) || w_last_cycle);
    assign w_accept     = byte_valid && byte_ready;

    assign w_new_frame  = build_frame(byte_data);
    assign w_new_qpsk   = (sel == MODE_QPSK);
    // Consumed bits drop out of the bottom; the mode is latched per frame so a
    // live sel change cannot alter the shift width mid-frame.
    assign w_shifted    = r_qpsk ? (r_frame >> 2) : (r_frame >> 1);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        w_state_next  = r_state;
        w_frame_next  = r_frame;
        w_qpsk_next   = r_qpsk;
        w_idx_next    = r_idx;
        w_sym_next    = r_sym;
        w_strobe_next = 1'b0;
        w_busy_next   = r_busy;
        w_timer_clear = 1'b0;

        if (ena) begin
            if (w_accept) begin
                // Covers both a fresh start from IDLE and a back-to-back
                // accept on the final cycle of the previous frame.
                w_state_next  = SEND;
                w_frame_next  = w_new_frame;
                w_qpsk_next   = w_new_qpsk;
                w_idx_next    = '0;
                w_sym_next    = map_symbol(w_new_frame[1:0], w_new_qpsk);
                w_strobe_next = 1'b1;
                w_busy_next   = 1'b1;
                w_timer_clear = 1'b1;
            end else if (r_state == IDLE) begin
                w_sym_next    = idle_symbol(sel);
                w_busy_next   = 1'b0;
                w_timer_clear = 1'b1;
            end else if (w_tick) begin
                if (w_last_sym) begin
                    w_state_next = IDLE;
                    w_idx_next   = '0;
                    w_sym_next   = idle_symbol(sel);
                    w_busy_next  = 1'b0;
                end else begin
                    w_frame_next  = w_shifted;
                    w_idx_next    = r_idx + 4'd1;
                    w_sym_next    = map_symbol(w_shifted[1:0], r_qpsk);
                    w_strobe_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame  <= '1;
            r_qpsk   <= 1'b0;
            r_idx    <= '0;
            r_sym    <= SYM_IDLE_1B;
            r_strobe <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_frame  <= w_frame_next;
            r_qpsk   <= w_qpsk_next;
            r_idx    <= w_idx_next;
            r_sym    <= w_sym_next;
            r_strobe <= w_strobe_next;
            r_busy   <= w_busy_next;
        end
    end

    assign sym_out    = r_sym;
    assign sym_strobe = r_strobe;
    assign busy       = r_busy;

endmodule
